// File: rtl/param_stack.sv
// -----------------------------------------------------------------------------
// param_stack
//   Parameterised LIFO stack with combinational top-of-stack read and a
//   one-cycle write. A simultaneous push and pop replaces the top entry.
//   Pushing when full or popping when empty leaves the stack untouched and
//   raises overflow / underflow.
//
// Parameters
//   WIDTH  data bits per entry (default 8)
//   DEPTH  number of entries, any integer >= 2 (default 32)
//   CW     count width, $clog2(DEPTH+1) (local)
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-high reset
//   push       in   write d_in onto the stack
//   pop        in   remove the top entry
//   d_in       in   push data [WIDTH-1:0]
//   err_clr    in   synchronous clear of the error flags
//                   (only with PARAM_STACK_STICKY_ERR_EN)
//   tos        out  current top-of-stack value, zero when empty
//   count      out  number of valid entries [CW-1:0]
//   full       out  count == DEPTH
//   empty      out  count == 0
//   overflow   out  push attempted while full
//   underflow  out  pop attempted while empty
//
// Configuration
//   PARAM_STACK_STICKY_ERR_EN  undefined (default): overflow/underflow are
//                              one-cycle pulses in the cycle after the
//                              offending edge.
//                              defined: the flags stay set until rst or
//                              err_clr; a new error in the clearing cycle
//                              wins over the clear.
// -----------------------------------------------------------------------------
module param_stack #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 32,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
`ifdef PARAM_STACK_STICKY_ERR_EN
    input  logic             err_clr,
`endif
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] tos,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    // Address width covers indices 0..DEPTH-1 only.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_REPL,
        OP_OVF,
        OP_UDF
    } op_e;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    op_e              op;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic             wr_en;
    logic             is_full;
    logic             is_empty;

    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);

    // top_idx is only meaningful when the stack is non-empty; the read mux
    // below masks the wrapped value seen when count_q is zero.
    assign top_idx  = AW'(count_q - CW'(1));

    // Operation decode and next state.
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        op      = OP_IDLE;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = top_idx;

        unique case ({push, pop})
            2'b10:   op = is_full  ? OP_OVF  : OP_PUSH;
            2'b01:   op = is_empty ? OP_UDF  : OP_POP;
            // Push+pop on an empty stack degrades to a plain push.
            2'b11:   op = is_empty ? OP_PUSH : OP_REPL;
            default: op = OP_IDLE;
        endcase

        unique case (op)
            OP_PUSH: begin
                wr_en   = 1'b1;
                wr_idx  = AW'(count_q);
                count_d = count_q + CW'(1);
            end
            OP_POP: begin
                count_d = count_q - CW'(1);
            end
            OP_REPL: begin
                wr_en   = 1'b1;
                wr_idx  = top_idx;
            end
            default: ;
        endcase

`ifdef PARAM_STACK_STICKY_ERR_EN
        // A new error in the same cycle as err_clr keeps the flag set.
        ovf_d = (op == OP_OVF) | (ovf_q & ~err_clr);
        udf_d = (op == OP_UDF) | (udf_q & ~err_clr);
`else
        ovf_d = (op == OP_OVF);
        udf_d = (op == OP_UDF);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // NOTE: storage has no reset; stale entries are unreachable because the
    // read mux only exposes indices below count_q, which reset clears.
    // Writes are suppressed while rst is high so an in-flight push is aborted.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_idx] <= d_in;
        end
    end

    assign tos       = is_empty ? '0 : mem_q[top_idx];
    assign count     = count_q;
    assign full      = is_full;
    assign empty     = is_empty;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule
